// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage with PC, ROM addressing and IF/ID register
module fetch_stage #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH)-1:0] rom_addr,
    input  logic [31:0]              rom_instr,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_pc4,
    output logic [31:0]              if_instr,
    output logic                     if_valid,
    output logic                     if_fault
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        in_range;

    // Sequential PC and its 32-bit wrapping increment; redirect targets are forced word aligned.
    always_comb begin
        pc_plus4        = pc + 32'd4;
        redirect_target = redirect_pc & ~32'h0000_0003;
        in_range        = (pc[31:ADDR_W+2] == '0);
        rom_addr        = pc[ADDR_W+1:2];
    end

    // PC register: redirect beats stall, stall holds, otherwise advance by one word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_target;
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID register: flush to a bubble on redirect, hold on stall, capture the fetch otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc    <= 32'h0000_0000;
            if_pc4   <= 32'h0000_0000;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
            if_fault <= 1'b0;
        end else if (redirect) begin
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
            if_fault <= 1'b0;
        end else if (!stall) begin
            if_pc    <= pc;
            if_pc4   <= pc_plus4;
            if_valid <= 1'b1;
            if (in_range) begin
                if_instr <= rom_instr;
                if_fault <= 1'b0;
            end else begin
                if_instr <= NOP_INSTR;
                if_fault <= 1'b1;
            end
        end
    end

endmodule
